recording_playback: RTL

//  Read-side counterpart of the switch Recording block. Fetches the stored run list
//  (level + duration in Div_CLK ticks, 0.1 ms each) from the recorder's sync-read

---
 rtl/recording_playback_if.sv | 24 ++
 rtl/recording_playback.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/recording_playback_if.sv
// Read port of the recorder's sync-read run memory.
// Each word is {level, duration}; data is valid the cycle after rd_en.
interface recording_playback_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DUR_W  = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DUR_W:0]    rd_data;

    // Playback side drives the read strobe and address.
    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    // Memory side returns the stored run word.
    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/recording_playback.sv
// Switch waveform playback: walks the recorded run list and regenerates the
// switch level tick-accurately, prefetching the next run during the current one.
module recording_playback #(
    parameter int unsigned DUR_W  = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                 Div_CLK,
    input  logic                 Rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [ADDR_W:0]      rec_len,
    recording_playback_if.master mem,
    output logic                 play_switch,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        LOAD0,
        PLAY
    } state_t;

    localparam logic [ADDR_W:0]  LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [DUR_W-1:0] MIN_DUR = DUR_W'(2);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    state_t state, state_nx;

    logic [ADDR_W:0]   len_q,     len_d;
    logic [ADDR_W-1:0] idx_q,     idx_d;
    logic [DUR_W-1:0]  cnt_q,     cnt_d;
    logic [DUR_W:0]    nbuf_q,    nbuf_d;
    logic              pend_q,    pend_d;
    logic              pf_q,      pf_d;
    logic              rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              play_q,    play_d;
    logic              done_q,    done_d;

    logic [ADDR_W:0]   len_in;
    logic              last_entry;
    logic              nlast;
    logic              cnt_end;
    logic              wrap_ok;
    logic              pf0;
    logic [ADDR_W-1:0] nidx;
    logic [DUR_W:0]    src;

    // Runs shorter than two ticks are stretched so the prefetch always lands in time.
    function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
        return (d < MIN_DUR) ? MIN_DUR : d;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_next(input logic [ADDR_W-1:0] i,
                                                    input logic [ADDR_W:0]   n);
        return ({1'b0, i} == n - LEN_ONE) ? '0 : i + ADDR_W'(1);
    endfunction

    assign len_in     = (rec_len > LEN_MAX) ? LEN_MAX : rec_len;
    assign last_entry = ({1'b0, idx_q} == len_q - LEN_ONE);
    assign nidx       = wrap_next(idx_q, len_q);
    assign nlast      = ({1'b0, nidx} == len_q - LEN_ONE);
    assign cnt_end    = (cnt_q == DUR_ONE);
    // Wrapping needs the entry-0 prefetch to have been issued at the start of the
    // last entry; if loop was low then, the pass ends even if loop rises later.
    assign wrap_ok    = loop && pf_q;
    assign pf0        = (len_q != LEN_ONE) || loop;
    // Next run comes straight off the bus when it arrives in the final cycle
    // (two-tick runs), otherwise from the prefetch buffer.
    assign src        = pend_q ? mem.rd_data : nbuf_q;

    assign mem.rd_en   = rd_en_q;
    assign mem.rd_addr = rd_addr_q;
    assign play_switch = play_q;
    assign done        = done_q;
    assign busy        = (state != IDLE);

    // State register.
    always_ff @(posedge Div_CLK or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; stop overrides every transition.
    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start && (len_in != '0)) state_nx = FETCH0;
                FETCH0:  state_nx = LOAD0;
                LOAD0:   state_nx = PLAY;
                PLAY:    if (cnt_end && last_entry && !wrap_ok) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output and datapath next values.
    always_comb begin
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nbuf_d    = nbuf_q;
        pend_d    = rd_en_q;
        pf_d      = pf_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        play_d    = play_q;
        done_d    = 1'b0;
        if (stop) begin
            pend_d = 1'b0;
            play_d = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    play_d = 1'b0;
                    if (start) begin
                        if (len_in == '0) begin
                            done_d = 1'b1;
                        end else begin
                            len_d     = len_in;
                            idx_d     = '0;
                            rd_en_d   = 1'b1;
                            rd_addr_d = '0;
                        end
                    end
                end
                FETCH0: begin
                end
                LOAD0: begin
                    play_d    = mem.rd_data[DUR_W];
                    cnt_d     = eff_dur(mem.rd_data[DUR_W-1:0]);
                    idx_d     = '0;
                    pf_d      = pf0;
                    rd_en_d   = pf0;
                    rd_addr_d = wrap_next('0, len_q);
                end
                PLAY: begin
                    if (pend_q) nbuf_d = mem.rd_data;
                    if (cnt_end) begin
                        if (last_entry && !wrap_ok) begin
                            play_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            idx_d     = nidx;
                            play_d    = src[DUR_W];
                            cnt_d     = eff_dur(src[DUR_W-1:0]);
                            pf_d      = !nlast || loop;
                            rd_en_d   = !nlast || loop;
                            rd_addr_d = wrap_next(nidx, len_q);
                        end
                    end else begin
                        cnt_d = cnt_q - DUR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge Div_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            nbuf_q    <= '0;
            pend_q    <= 1'b0;
            pf_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            play_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            nbuf_q    <= nbuf_d;
            pend_q    <= pend_d;
            pf_q      <= pf_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            play_q    <= play_d;
            done_q    <= done_d;
        end
    end

endmodule
